// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the 5-stage pipeline control / hazard unit.
// The cause encoding is also consumed by the debug trace.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        LOAD_USE   = 2'd1,
        FLUSH      = 2'd2,
        MEM_FREEZE = 2'd3
    } cause_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Pipeline-register control bundle, MSB first in PC -> WB order.
    typedef struct packed {
        logic pc_ld;
        logic if_id_ld;
        logic if_id_clr_n;
        logic id_ex_ld;
        logic id_ex_clr_n;
        logic ex_mem_ld;
        logic mem_wb_ld;
        logic mem_wb_clr_n;
    } ctrl_t;

    function automatic ctrl_t cause_ctrl(input cause_e c);
        ctrl_t r;
        r = '1;
        case (c)
            MEM_FREEZE: begin
                r              = '1;
                r.pc_ld        = 1'b0;
                r.if_id_ld     = 1'b0;
                r.id_ex_ld     = 1'b0;
                r.ex_mem_ld    = 1'b0;
                r.mem_wb_ld    = 1'b0;
                r.mem_wb_clr_n = 1'b0;
            end
            FLUSH: begin
                r.if_id_clr_n  = 1'b0;
                r.id_ex_clr_n  = 1'b0;
            end
            // ID/EX keeps its load enable so the clear captures a bubble.
            LOAD_USE: begin
                r.pc_ld        = 1'b0;
                r.if_id_ld     = 1'b0;
                r.id_ex_clr_n  = 1'b0;
            end
            default: r = '1;
        endcase
        return r;
    endfunction

    function automatic logic load_use_hit(input logic       memread,
                                          input logic [4:0] ex_rt,
                                          input logic [4:0] id_rs,
                                          input logic [4:0] id_rt,
                                          input logic       uses_rt);
        return memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-unit bundle: pipeline status in, register enables/clears and debug counters out.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_ld;
    logic             if_id_ld;
    logic             if_id_clr_n;
    logic             id_ex_ld;
    logic             id_ex_clr_n;
    logic             ex_mem_ld;
    logic             mem_wb_ld;
    logic             mem_wb_clr_n;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_ld, if_id_ld, if_id_clr_n, id_ex_ld, id_ex_clr_n,
               ex_mem_ld, mem_wb_ld, mem_wb_clr_n, mem_err,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               ex_branch_taken, mem_req, mem_ready,
        output pc_ld, if_id_ld, if_id_clr_n, id_ex_ld, id_ex_clr_n,
               ex_mem_ld, mem_wb_ld, mem_wb_clr_n, mem_err,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control and hazard unit: load-use stalls, branch flushes, memory
// wait-state freeze with timeout flag, and saturating stall/flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    state_e              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                mem_err, mem_err_nxt;
    logic                freeze;
    logic                lu_hit;
    cause_e              cause;
    ctrl_t               ctrl;
    logic                stall_inc;
    logic                flush_inc;
    logic [CNT_W-1:0]    stall_cycles;
    logic [CNT_W-1:0]    flush_count;

    // Cause selection, highest priority first.
    always_comb begin
        freeze = bus.mem_req && !bus.mem_ready;
        lu_hit = load_use_hit(bus.ex_memread, bus.ex_rt, bus.id_rs,
                              bus.id_rt, bus.id_uses_rt);
        cause  = NORMAL;
        if (freeze)
            cause = MEM_FREEZE;
        else if (bus.ex_branch_taken)
            cause = FLUSH;
        else if (lu_hit)
            cause = LOAD_USE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err;
        ctrl         = reset ? cause_ctrl(cause) : '0;

        case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (!freeze) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    // Timeout is only reported; the freeze keeps holding the pipe.
                    mem_err_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign stall_inc = reset && ((cause == MEM_FREEZE) || (cause == LOAD_USE));
    assign flush_inc = reset && (cause == FLUSH);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

    assign bus.pc_ld        = ctrl.pc_ld;
    assign bus.if_id_ld     = ctrl.if_id_ld;
    assign bus.if_id_clr_n  = ctrl.if_id_clr_n;
    assign bus.id_ex_ld     = ctrl.id_ex_ld;
    assign bus.id_ex_clr_n  = ctrl.id_ex_clr_n;
    assign bus.ex_mem_ld    = ctrl.ex_mem_ld;
    assign bus.mem_wb_ld    = ctrl.mem_wb_ld;
    assign bus.mem_wb_clr_n = ctrl.mem_wb_clr_n;
    assign bus.mem_err      = mem_err;
    assign bus.stall_cycles = stall_cycles;
    assign bus.flush_count  = flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, directed multi-cycle sequences and random
// stimulus against a cycle-level reference model (one 16-bit and one 4-bit DUT).
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MAXW = 15;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(16)) bus  ();
    pipe_ctrl_if #(.CNT_W(4))  bus4 ();

    pipe_ctrl #(.CNT_W(16), .MAX_WAIT(MAXW)) dut  (.clk(clk), .reset(reset), .bus(bus));
    pipe_ctrl #(.CNT_W(4),  .MAX_WAIT(MAXW)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: counters as plain ints, freeze tracked as run length.
    int m_stall  = 0, m_flush  = 0;
    int m_stall4 = 0, m_flush4 = 0;
    int m_run    = 0;
    bit m_err    = 1'b0;

    function automatic in_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic uses_rt,
                               logic memread, logic [4:0] ex_rt, logic br,
                               logic req, logic rdy);
        in_t i;
        i.rst = rst; i.rs = rs; i.rt = rt; i.uses_rt = uses_rt; i.memread = memread;
        i.ex_rt = ex_rt; i.br = br; i.req = req; i.rdy = rdy;
        return i;
    endfunction

    // Order: pc_ld if_id_ld if_id_clr_n id_ex_ld id_ex_clr_n ex_mem_ld mem_wb_ld mem_wb_clr_n
    function automatic logic [7:0] model_ctrl(in_t i);
        if (!i.rst)                  return 8'b0000_0000;
        if (i.req && !i.rdy)         return 8'b0010_1000;
        if (i.br)                    return 8'b1101_0111;
        if (i.memread && i.ex_rt != 5'd0 &&
            (i.ex_rt == i.rs || (i.uses_rt && i.ex_rt == i.rt)))
                                     return 8'b0011_0111;
        return 8'b1111_1111;
    endfunction

    function automatic int sat_inc(int v, int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(in_t i);
        reset = i.rst;
        bus.id_rs  = i.rs;    bus4.id_rs  = i.rs;
        bus.id_rt  = i.rt;    bus4.id_rt  = i.rt;
        bus.id_uses_rt = i.uses_rt;  bus4.id_uses_rt = i.uses_rt;
        bus.ex_memread = i.memread;  bus4.ex_memread = i.memread;
        bus.ex_rt  = i.ex_rt; bus4.ex_rt  = i.ex_rt;
        bus.ex_branch_taken = i.br;  bus4.ex_branch_taken = i.br;
        bus.mem_req   = i.req; bus4.mem_req   = i.req;
        bus.mem_ready = i.rdy; bus4.mem_ready = i.rdy;
    endtask

    // One clock: drive, check combinational outputs and current state, advance model.
    task automatic step(in_t i);
        logic [7:0] act;
        logic [7:0] exp;
        bit         frz;
        drive(i);
        #1;
        act = {bus.pc_ld, bus.if_id_ld, bus.if_id_clr_n, bus.id_ex_ld,
               bus.id_ex_clr_n, bus.ex_mem_ld, bus.mem_wb_ld, bus.mem_wb_clr_n};
        exp = model_ctrl(i);
        chk("ctrl", act, exp);
        chk("stall_cycles", bus.stall_cycles, m_stall);
        chk("flush_count", bus.flush_count, m_flush);
        chk("stall_cycles_w4", bus4.stall_cycles, m_stall4);
        chk("flush_count_w4", bus4.flush_count, m_flush4);
        chk("mem_err", bus.mem_err, m_err);

        if (!i.rst) begin
            m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
            m_run = 0; m_err = 1'b0;
        end else begin
            frz = i.req && !i.rdy;
            if (exp == 8'b0010_1000 || exp == 8'b0011_0111) begin
                m_stall  = sat_inc(m_stall, 65535);
                m_stall4 = sat_inc(m_stall4, 15);
            end
            if (exp == 8'b1101_0111) begin
                m_flush  = sat_inc(m_flush, 65535);
                m_flush4 = sat_inc(m_flush4, 15);
            end
            // Entry cycle plus MAX_WAIT+1 frozen WAIT edges trips the timeout.
            m_run = frz ? m_run + 1 : 0;
            if (m_run >= MAXW + 2) m_err = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        in_t rst_i, lu, nrm0, brlu, frz, rdy, fl, ri;
        int hold;

        rst_i = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        lu    = mk(1, 5, 0, 0, 1, 5, 0, 0, 1);
        nrm0  = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
        brlu  = mk(1, 5, 0, 0, 1, 5, 1, 0, 1);
        frz   = mk(1, 1, 2, 1, 0, 3, 0, 1, 0);
        rdy   = mk(1, 1, 2, 1, 0, 3, 0, 1, 1);
        fl    = mk(1, 0, 0, 0, 0, 0, 1, 0, 1);

        vecs.push_back('{"reset",        mk(0, 5, 0, 0, 1, 5, 1, 1, 0), 8'b0000_0000});
        vecs.push_back('{"normal",       mk(1, 1, 2, 1, 0, 1, 0, 0, 1), 8'b1111_1111});
        vecs.push_back('{"lu_rs",        mk(1, 9, 4, 0, 1, 9, 0, 0, 1), 8'b0011_0111});
        vecs.push_back('{"lu_rt",        mk(1, 3, 7, 1, 1, 7, 0, 0, 1), 8'b0011_0111});
        vecs.push_back('{"rt_unused",    mk(1, 3, 7, 0, 1, 7, 0, 0, 1), 8'b1111_1111});
        vecs.push_back('{"no_memread",   mk(1, 7, 7, 1, 0, 7, 0, 0, 1), 8'b1111_1111});
        vecs.push_back('{"rt_zero",      mk(1, 0, 0, 1, 1, 0, 0, 0, 1), 8'b1111_1111});
        vecs.push_back('{"flush",        mk(1, 1, 2, 0, 0, 4, 1, 0, 1), 8'b1101_0111});
        vecs.push_back('{"freeze_br_lu", mk(1, 6, 0, 0, 1, 6, 1, 1, 0), 8'b0010_1000});
        vecs.push_back('{"req_ready",    mk(1, 6, 0, 0, 1, 6, 1, 1, 1), 8'b1101_0111});
        vecs.push_back('{"idle_mem",     mk(1, 6, 0, 0, 0, 6, 0, 0, 0), 8'b1111_1111});

        step(rst_i);
        step(rst_i);
        chk("rst_stall", bus.stall_cycles, 0);
        chk("rst_flush", bus.flush_count, 0);
        chk("rst_mem_err", bus.mem_err, 0);

        // Load-use: one stall cycle, then r0 never stalls.
        step(lu);
        chk("lu_stall_cnt", bus.stall_cycles, 1);
        step(nrm0);
        chk("rt0_stall_cnt", bus.stall_cycles, 1);
        step(brlu);
        chk("br_lu_flush_cnt", bus.flush_count, 1);
        chk("br_lu_stall_cnt", bus.stall_cycles, 1);

        // Three-cycle memory wait.
        repeat (3) step(frz);
        step(rdy);
        chk("wait3_stall_cnt", bus.stall_cycles, 4);
        chk("wait3_mem_err", bus.mem_err, 0);

        // Timeout: set after the 17th frozen cycle, sticky, cleared by reset.
        step(rst_i);
        repeat (16) step(frz);
        chk("timeout_pre", bus.mem_err, 0);
        step(frz);
        chk("timeout_set", bus.mem_err, 1);
        repeat (3) step(frz);
        chk("timeout_sticky", bus.mem_err, 1);
        step(mk(0, 1, 2, 1, 0, 3, 0, 1, 0));
        chk("timeout_rst", bus.mem_err, 0);
        repeat (16) step(frz);
        chk("timeout_restart_pre", bus.mem_err, 0);
        step(frz);
        chk("timeout_restart_set", bus.mem_err, 1);

        // Counter saturation on the 4-bit instance.
        step(rst_i);
        repeat (20) step(fl);
        chk("flush_sat_w4", bus4.flush_count, 15);
        chk("flush_w16", bus.flush_count, 20);

        step(rst_i);
        foreach (vecs[k]) begin
            step(vecs[k].in);
        end
        foreach (vecs[k]) begin
            logic [7:0] act;
            drive(vecs[k].in);
            #1;
            act = {bus.pc_ld, bus.if_id_ld, bus.if_id_clr_n, bus.id_ex_ld,
                   bus.id_ex_clr_n, bus.ex_mem_ld, bus.mem_wb_ld, bus.mem_wb_clr_n};
            chk({"vec_", vecs[k].name}, act, vecs[k].exp);
            step(vecs[k].in);
        end

        // Random traffic with occasional long memory stalls and resets.
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            ri = mk(($urandom % 60) != 0,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom), 5'($urandom_range(0, 3)), ($urandom % 6) == 0,
                    ($urandom % 3) == 0, ($urandom % 3) != 0);
            if (hold == 0 && ($urandom % 80) == 0) hold = $urandom_range(5, 25);
            if (hold > 0) begin
                ri.req = 1'b1; ri.rdy = 1'b0; ri.rst = 1'b1;
                hold--;
            end
            step(ri);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control and hazard unit for the 5-stage MIPS core. It sequences the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) by driving their load enables and active-low synchronous clears. It resolves load-use stalls, taken-branch flushes and data-memory wait states. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters
- MAX_WAIT, 15, memory-wait cycles tolerated before `mem_err` is set

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  EX instruction is a load
- ex_rt  in  5  destination register of the load in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_ld  out  1  PC load enable
- if_id_ld  out  1  IF/ID load enable
- if_id_clr_n  out  1  IF/ID clear, active-low
- id_ex_ld  out  1  ID/EX load enable
- id_ex_clr_n  out  1  ID/EX clear (bubble), active-low
- ex_mem_ld  out  1  EX/MEM load enable
- mem_wb_ld  out  1  MEM/WB load enable
- mem_wb_clr_n  out  1  MEM/WB clear (bubble), active-low
- mem_err  out  1  sticky memory-timeout flag
- stall_cycles  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of taken-branch flushes

## Operation
- Control outputs are combinational from the inputs and state. Exactly one case applies per cycle, in this priority order:
  1. **Reset** (`reset`=0): all `*_ld`=0 and all `*_clr_n`=0.
  2. **MEM_FREEZE** (`mem_req`=1 and `mem_ready`=0):
     - all `*_ld`=0, `mem_wb_clr_n`=0, other clears=1.
     - A bubble enters WB; every other stage holds.
  3. **FLUSH** (`ex_branch_taken`=1):
     - all `*_ld`=1, `if_id_clr_n`=0, `id_ex_clr_n`=0.
     - The two wrong-path instructions are discarded.
  4. **LOAD_USE** (`ex_memread`=1, `ex_rt`≠0, and either `ex_rt`==`id_rs` or (`id_uses_rt` and `ex_rt`==`id_rt`)):
     - `pc_ld`=0, `if_id_ld`=0, `id_ex_clr_n`=0.
     - `ex_mem_ld`=1, `mem_wb_ld`=1, other clears=1.
  5. **NORMAL**: all `*_ld`=1, all `*_clr_n`=1.
- If a branch and a load-use occur in the same cycle, the branch wins: the dependent instruction is wrong-path.
- FSM states:
  - **RUN** → **WAIT** when MEM_FREEZE occurs.
  - **WAIT** → **RUN** on the cycle `mem_ready`=1 or `mem_req`=0.
  - `wait_cnt` clears on entry to WAIT and increments each WAIT cycle, saturating at MAX_WAIT.
- `mem_err`:
  - Set at the clock edge where the state is WAIT, `wait_cnt`==MAX_WAIT and the freeze persists.
  - Stays set until reset.
  - The pipeline keeps freezing; the freeze is not aborted.
- `stall_cycles` increments on every MEM_FREEZE or LOAD_USE cycle.
- `flush_count` increments on every FLUSH cycle.
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset values: state RUN, `wait_cnt`=0, `mem_err`=0, both counters 0. Control outputs follow case 1 while `reset`=0.
- Control outputs have zero latency from inputs. State, `wait_cnt`, `mem_err` and counters update on the rising edge.
- A load-use stall lasts exactly 1 cycle, because the bubble clears `ex_memread` in the next cycle.
- A memory wait of N cycles (`mem_ready` low for N cycles) freezes for exactly N cycles. Normal operation resumes in the `mem_ready` cycle.
- A reset asserted during WAIT returns the state to RUN next edge and clears `mem_err`.
- A counter increment coincident with reset is dropped.

## Structure
- Package `pipe_ctrl_pkg`:
  - state enum (RUN, WAIT)
  - `REG_ZERO` = 5'd0
  - cause encoding (NORMAL, LOAD_USE, FLUSH, MEM_FREEZE) shared with the debug trace
- Sub-module `sat_counter` (parameter W; inputs: clk, reset, inc; output: count), instantiated twice for the performance counters.

## Test plan
- Load `ex_rt`=5 with `ex_memread`=1 and `id_rs`=5 → one cycle with `pc_ld`=0, `if_id_ld`=0, `id_ex_clr_n`=0; `stall_cycles`=1.
- Same case with `ex_rt`=0 → NORMAL, no stall; `stall_cycles` unchanged.
- `ex_branch_taken`=1 together with a load-use match → FLUSH outputs (`if_id_clr_n`=0, `id_ex_clr_n`=0, `pc_ld`=1); `flush_count`=1; `stall_cycles` unchanged.
- `mem_req`=1 with `mem_ready` low for 3 cycles → 3 frozen cycles with `mem_wb_clr_n`=0; 4th cycle NORMAL; `stall_cycles`=3; `mem_err`=0.
- `mem_ready` held low for 20 cycles with MAX_WAIT=15 → `mem_err` rises after 16 WAIT edges, stays 1; a single-cycle reset clears it and returns the state to RUN.
- CNT_W=4 with 20 flushes → `flush_count` holds at 15.
